adbg_jtag_tap: RTL
==================

# adbg_jtag_tap

IEEE 1149.1 TAP controller that sits directly upstream of the debug top level. It converts the raw JTAG pins (TCK/TMS/TDI/TDO) into the TAP-state strobes and debug instruction select consumed by the debug top level. It owns the instruction register, the BYPASS and IDCODE data registers, and the negedge TDO output stage. It multiplexes the debug chain's TDO when the DEBUG instruction is active.

## Interface

Parameters:
- IR_LEN, 4, instruction register width (≥2)
- IDCODE_VALUE, 32'h1495_11C3, 32-bit IDCODE; bit 0 must be 1
- IDCODE_OPCODE, 4'b0010, IDCODE instruction
- DEBUG_OPCODE, 4'b1000, debug-chain instruction
- BYPASS opcode is fixed all-ones; all undefined opcodes decode as BYPASS

Ports:
- tck_i  in  1  JTAG clock
- trstn_i  in  1  reset, asynchronous, active-low
- tms_i  in  1  test mode select, sampled on posedge tck_i
- tdi_i  in  1  test data in
- tdo_o  out  1  test data out, updated on negedge tck_i
- tdo_oe_o  out  1  TDO output enable, updated on negedge tck_i
- debug_tdo_i  in  1  TDO from the debug top level
- test_logic_reset_o  out  1  high in Test-Logic-Reset
- run_test_idle_o  out  1  high in Run-Test/Idle
- capture_dr_o  out  1  high in Capture-DR
- shift_dr_o  out  1  high in Shift-DR
- pause_dr_o  out  1  high in Pause-DR
- update_dr_o  out  1  high in Update-DR
- debug_select_o  out  1  active instruction == DEBUG_OPCODE

## Operation

- FSM: 16 standard TAP states, stored in a registered state vector clocked on posedge tck_i.
- Transitions follow 1149.1 exactly: TLR -(0)-> RTI, RTI -(1)-> SelDR, SelDR -(1)-> SelIR, SelIR -(1)-> TLR, Capture -(0)-> Shift, Shift -(1)-> Exit1, Exit1 -(0)-> Pause, Pause -(1)-> Exit2, Exit2 -(0)-> Shift, Exit1/Exit2 -(1)-> Update, Update -(0)-> RTI, Update -(1)-> SelDR.
- Any state reaches TLR after 5 consecutive TMS=1 clocks.
- State strobes are a combinational decode of the state register; no glitch-sensitive logic is driven from them.
- IR shift register (IR_LEN bits):
  - Capture-IR loads {0…0,01}.
  - Shift-IR shifts right with tdi_i entering the MSB.
- Active instruction register:
  - Loaded from the IR shift register on negedge tck_i while in Update-IR.
  - Forced to the reset instruction in TLR.
- BYPASS register (1 bit): cleared in Capture-DR; takes tdi_i in Shift-DR.
- IDCODE register (32 bit): loads IDCODE_VALUE in Capture-DR; shifts right in Shift-DR.
- The DEBUG data path is external; only debug_tdo_i is muxed.
- TDO mux, registered on negedge:
  - Shift-IR: IR shift bit 0.
  - Shift-DR: debug_tdo_i, IDCODE bit 0 or BYPASS, selected by the active instruction.
  - Otherwise: tdo_o holds and tdo_oe_o=0.
- tdo_oe_o = 1 on the negedge following entry to Shift-IR/Shift-DR; 0 on the negedge after leaving.
- Reset values (trstn_i low):
  - state=TLR, IR shift=0, active instruction = reset instruction.
  - BYPASS=0, IDCODE SR=IDCODE_VALUE, tdo_o=0, tdo_oe_o=0.
  - test_logic_reset_o=1, all other strobes 0, debug_select_o=0.
- Reset mid-shift aborts immediately; no Update occurs.

## Timing

- State changes on posedge tck_i; strobes are valid for the full following cycle, so downstream sampling on posedge sees each strobe for exactly the cycles spent in that state.
- First shifted data bit appears on tdo_o at the negedge after entering Shift-xR, i.e. half a TCK after the posedge.
- debug_select_o changes on the negedge in Update-IR and is stable before the next posedge.
- debug_tdo_i is sampled on negedge; the downstream block must present it combinationally or from posedge logic.
- DR length in BYPASS is 1: TDI to TDO latency is 1 TCK in Shift-DR.

## Configuration

- ADBG_TAP_IDCODE_EN defined:
  - The IDCODE register exists.
  - The reset instruction is IDCODE_OPCODE.
  - The first DR scan after reset returns IDCODE_VALUE LSB-first.
- ADBG_TAP_IDCODE_EN undefined:
  - No IDCODE register.
  - IDCODE_OPCODE decodes as BYPASS.
  - The reset instruction is BYPASS.
  - The first DR scan returns a leading 0.

## Test plan

- Hold trstn_i=0, then release; with TMS=0 for 1 clock: state RTI, run_test_idle_o=1, tdo_oe_o=0, debug_select_o=0.
- From RTI, TMS=1×5 -> test_logic_reset_o=1; repeat from each of the 16 states (driven by a TMS walk) -> TLR in ≤5 clocks.
- After reset with IDCODE_EN, scan 32-bit DR with TDI=0 -> tdo_o sequence equals 32'h1495_11C3 LSB-first.
- Scan IR with 4'b1111 -> the IR capture returns 4'b0001 on TDO. Then scan an 8-bit DR with 8'hA5 -> TDO returns 0 followed by the first 7 bits of A5 (1-bit delay).
- Load IR=4'b1000 -> debug_select_o=1 at the Update-IR negedge. In Shift-DR, toggling debug_tdo_i is mirrored on tdo_o one negedge later, and shift_dr_o is high for exactly the N shift clocks.
- Assert trstn_i mid Shift-DR -> tdo_oe_o=0 and state=TLR immediately; update_dr_o never pulses; active IR = reset instruction.

Source files
------------

// File: rtl/adbg_jtag_tap_if.sv
// Debug-side signal bundle of the JTAG TAP: TAP-state strobes, instruction select and the debug chain TDO.
// master = TAP controller, slave = debug top level.
interface adbg_jtag_tap_if;
  logic debug_tdo_i;
  logic test_logic_reset_o;
  logic run_test_idle_o;
  logic capture_dr_o;
  logic shift_dr_o;
  logic pause_dr_o;
  logic update_dr_o;
  logic debug_select_o;

  modport master (
    input  debug_tdo_i,
    output test_logic_reset_o,
    output run_test_idle_o,
    output capture_dr_o,
    output shift_dr_o,
    output pause_dr_o,
    output update_dr_o,
    output debug_select_o
  );

  modport slave (
    output debug_tdo_i,
    input  test_logic_reset_o,
    input  run_test_idle_o,
    input  capture_dr_o,
    input  shift_dr_o,
    input  pause_dr_o,
    input  update_dr_o,
    input  debug_select_o
  );
endinterface

// File: rtl/adbg_jtag_tap.sv
// IEEE 1149.1 TAP controller with IR, BYPASS, optional IDCODE and negedge TDO stage.
// Define ADBG_TAP_IDCODE_EN to build the IDCODE register and make IDCODE the reset instruction.
module adbg_jtag_tap #(
  parameter int unsigned        IR_LEN        = 4,
  parameter logic [31:0]        IDCODE_VALUE  = 32'h1495_11C3,
  parameter logic [IR_LEN-1:0]  IDCODE_OPCODE = IR_LEN'(4'b0010),
  parameter logic [IR_LEN-1:0]  DEBUG_OPCODE  = IR_LEN'(4'b1000)
) (
  input  logic            tck_i,
  input  logic            trstn_i,
  input  logic            tms_i,
  input  logic            tdi_i,
  output logic            tdo_o,
  output logic            tdo_oe_o,
  adbg_jtag_tap_if.master dbg
);

  localparam int unsigned       IDCODE_LEN = 32;
  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] BYPASS_OP  = '1;
`ifdef ADBG_TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] RESET_INSTR = IDCODE_OPCODE;
`else
  localparam logic [IR_LEN-1:0] RESET_INSTR = BYPASS_OP;
`endif

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI,
    ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT1_DR, ST_PAUSE_DR, ST_EXIT2_DR, ST_UPD_DR,
    ST_SEL_IR, ST_CAP_IR, ST_SHIFT_IR, ST_EXIT1_IR, ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR
  } tap_state_e;

  tap_state_e        state_q, state_d;
  logic [IR_LEN-1:0] ir_sr_q;
  logic [IR_LEN-1:0] ir_q;
  logic              bypass_q;
  logic              dr_tdo_c;

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) state_q <= ST_TLR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:      state_d = tms_i ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = tms_i ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = tms_i ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = tms_i ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: state_d = tms_i ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: state_d = tms_i ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = tms_i ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: state_d = tms_i ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   state_d = tms_i ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = tms_i ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = tms_i ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: state_d = tms_i ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: state_d = tms_i ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = tms_i ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: state_d = tms_i ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   state_d = tms_i ? ST_SEL_DR   : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  // Strobes decode straight from the state register, so they are stable for the whole TCK cycle.
  assign dbg.test_logic_reset_o = (state_q == ST_TLR);
  assign dbg.run_test_idle_o    = (state_q == ST_RTI);
  assign dbg.capture_dr_o       = (state_q == ST_CAP_DR);
  assign dbg.shift_dr_o         = (state_q == ST_SHIFT_DR);
  assign dbg.pause_dr_o         = (state_q == ST_PAUSE_DR);
  assign dbg.update_dr_o        = (state_q == ST_UPD_DR);
  assign dbg.debug_select_o     = (ir_q == DEBUG_OPCODE);

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      ir_sr_q <= '0;
    end else if (state_q == ST_CAP_IR) begin
      ir_sr_q <= IR_CAPTURE;
    end else if (state_q == ST_SHIFT_IR) begin
      ir_sr_q <= {tdi_i, ir_sr_q[IR_LEN-1:1]};
    end
  end

  // Active instruction changes on negedge so decode is settled before the next posedge.
  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      ir_q <= RESET_INSTR;
    end else if (state_q == ST_TLR) begin
      ir_q <= RESET_INSTR;
    end else if (state_q == ST_UPD_IR) begin
      ir_q <= ir_sr_q;
    end
  end

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      bypass_q <= 1'b0;
    end else if (state_q == ST_CAP_DR) begin
      bypass_q <= 1'b0;
    end else if (state_q == ST_SHIFT_DR) begin
      bypass_q <= tdi_i;
    end
  end

`ifdef ADBG_TAP_IDCODE_EN
  logic [IDCODE_LEN-1:0] idcode_sr_q;

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      idcode_sr_q <= IDCODE_VALUE;
    end else if (state_q == ST_CAP_DR) begin
      idcode_sr_q <= IDCODE_VALUE;
    end else if (state_q == ST_SHIFT_DR) begin
      idcode_sr_q <= {tdi_i, idcode_sr_q[IDCODE_LEN-1:1]};
    end
  end

  always_comb begin
    dr_tdo_c = bypass_q;
    if (ir_q == DEBUG_OPCODE)       dr_tdo_c = dbg.debug_tdo_i;
    else if (ir_q == IDCODE_OPCODE) dr_tdo_c = idcode_sr_q[0];
  end
`else
  always_comb begin
    dr_tdo_c = bypass_q;
    if (ir_q == DEBUG_OPCODE) dr_tdo_c = dbg.debug_tdo_i;
  end
`endif

  // Negedge output stage; TDO holds its last value while not shifting.
  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else if (state_q == ST_SHIFT_IR) begin
      tdo_o    <= ir_sr_q[0];
      tdo_oe_o <= 1'b1;
    end else if (state_q == ST_SHIFT_DR) begin
      tdo_o    <= dr_tdo_c;
      tdo_oe_o <= 1'b1;
    end else begin
      tdo_oe_o <= 1'b0;
    end
  end

endmodule
